alu_cy_unit: RTL and testbench
==============================

Name: alu_cy_unit

Overview:
- 8-bit combinational ALU paired with a single-bit carry flag register.
- Accumulator (A) and operand (R) come from the datapath; the result goes back to the accumulator input.
- The carry-out is captured into the carry flag under a clock enable.
- The registered carry feeds back as carry-in for ADC/SBB, forming the microprocessor's arithmetic core.

Parameters:
- WIDTH, 8, data width of A, R and out (all tests at 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_code  in  3  operation select.
- a  in  WIDTH  accumulator operand.
- r  in  WIDTH  second operand (register/immediate).
- cy_ce  in  1  carry flag clock enable.
- out  out  WIDTH  combinational result.
- co  out  1  combinational carry/borrow out of the current operation.
- cy  out  1  registered carry flag; also the internal carry-in.

Behaviour:
- out and co are purely combinational from alu_code, a, r and cy, with zero latency.
- Operations (ci = cy):
  - 0 ADD: {co,out} = a + r.
  - 1 ADC: {co,out} = a + r + ci.
  - 2 SUB: out = a - r; co = 1 when borrow (a < r).
  - 3 SBB: out = a - r - ci; co = 1 when borrow (a < r + ci, unsigned, WIDTH+1 bits).
  - 4 AND: out = a & r; co = 0.
  - 5 OR: out = a | r; co = 0.
  - 6 XOR: out = a ^ r; co = 0.
  - 7 PASS: out = r; co = 0.
- Arithmetic is unsigned modulo 2^WIDTH; co is bit WIDTH of the WIDTH+1-bit result (borrow for SUB/SBB).
- Carry register:
  - On rising clk edge with cy_ce = 1, cy <= co.
  - With cy_ce = 0, cy holds its value.
  - rst_n low forces cy = 0 immediately, regardless of clk; release is synchronous to the next edge.
- Reset: cy = 0. out/co have no reset and follow their inputs.
- Same-cycle ADC/SBB with cy_ce = 1 uses the old cy as carry-in and stores the new co; there is no combinational loop.
- Wrap-around:
  - 0xFF + 0x01 gives out 0x00, co 1.
  - 0x00 - 0x01 gives out 0xFF, co 1.
- Unknown/X alu_code is not legal; the default branch behaves as PASS.

Optional Feature:
- Macro: ALU_ZFLAG_EN.
- When defined:
  - Adds output port zf (1 bit), a registered zero flag.
  - zf <= (out == 0) on the same cy_ce edge as cy.
  - Reset value is 0.
- When undefined:
  - Port zf and its register are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS}.
  - localparam ALU_W = 8.
- One sub-module is natural: cy_flag_reg, a 1-bit enabled flop with async active-low reset (ports clk, rst_n, ce, d, q).
- cy_flag_reg is reused for zf when ALU_ZFLAG_EN is defined.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with cy previously 1 -> cy = 0 immediately, without waiting for a clk edge.
- ADD: a = 8, r = 4, code 0 -> out = 12, co = 0. ADD overflow: a = 0xFF, r = 0x01 -> out = 0x00, co = 1; pulse cy_ce -> cy = 1 after edge.
- ADC chain: cy = 1, a = 8, r = 4, code 1 -> out = 13, co = 0. With cy_ce = 1, cy = 0 after the edge.
- SUB/SBB: a = 4, r = 8, code 2 -> out = 0xFC, co = 1. Latch cy = 1, then a = 8, r = 4, code 3 -> out = 3, co = 0.
- Logic/PASS: a = 0xF0, r = 0x3C -> AND 0x30, OR 0xFC, XOR 0xCC, PASS 0x3C, co = 0 each. With cy_ce = 0, cy holds its prior value.
- ALU_ZFLAG_EN build: a = 5, r = 5, code 2, cy_ce = 1 -> out = 0, zf = 1 and cy = 0 after the edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/carry-flag arithmetic core: opcode encoding and default width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADC  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_SBB  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_cy_unit_flag_reg.sv
// Single-bit flag flop with clock enable and asynchronous active-low reset to 0.
module cy_flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic flag_d;
  logic flag_q;

  // Next-state select: load on enable, otherwise hold.
  always_comb begin
    if (ce) begin
      flag_d = d;
    end else begin
      flag_d = flag_q;
    end
  end

  // Flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign q = flag_q;

endmodule

// File: rtl/alu_cy_unit.sv
// Combinational ALU with registered carry flag fed back as carry-in for ADC/SBB.
// Optional registered zero flag output zf when ALU_ZFLAG_EN is defined.
module alu_cy_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] r,
  input  logic             cy_ce,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             cy
`ifdef ALU_ZFLAG_EN
  ,
  output logic             zf
`endif
);

  logic [WIDTH:0] a_ext_s;
  logic [WIDTH:0] r_ext_s;
  logic [WIDTH:0] ci_ext_s;
  logic [WIDTH:0] res_s;

  assign a_ext_s  = {1'b0, a};
  assign r_ext_s  = {1'b0, r};
  assign ci_ext_s = {{WIDTH{1'b0}}, cy};

  // Bit WIDTH of the widened result is carry for adds and borrow for subtracts;
  // cy is the stored flag, so ADC/SBB with cy_ce high never loops back combinationally.
  always_comb begin
    res_s = {(WIDTH+1){1'b0}};
    case (alu_op_e'(alu_code))
      ALU_ADD:  res_s = a_ext_s + r_ext_s;
      ALU_ADC:  res_s = a_ext_s + r_ext_s + ci_ext_s;
      ALU_SUB:  res_s = a_ext_s - r_ext_s;
      ALU_SBB:  res_s = a_ext_s - r_ext_s - ci_ext_s;
      ALU_AND:  res_s = {1'b0, a & r};
      ALU_OR:   res_s = {1'b0, a | r};
      ALU_XOR:  res_s = {1'b0, a ^ r};
      ALU_PASS: res_s = r_ext_s;
      default:  res_s = r_ext_s;
    endcase
  end

  assign out = res_s[WIDTH-1:0];
  assign co  = res_s[WIDTH];

  cy_flag_reg u_cy_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (cy_ce),
    .d     (co),
    .q     (cy)
  );

`ifdef ALU_ZFLAG_EN
  logic zero_s;

  assign zero_s = (out == {WIDTH{1'b0}});

  cy_flag_reg u_zf_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (cy_ce),
    .d     (zero_s),
    .q     (zf)
  );
`endif

endmodule

// File: tb/tb_alu_cy_unit.sv
// Self-checking bench for alu_cy_unit: directed cases plus random ops against an integer model.
`timescale 1ns/1ps
module tb_alu_cy_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] alu_code;
  logic [7:0] a;
  logic [7:0] r;
  logic       cy_ce;
  logic [7:0] out;
  logic       co;
  logic       cy;
`ifdef ALU_ZFLAG_EN
  logic       zf;
  int         model_zf;
`endif

  int tests_run;
  int tests_failed;
  int model_cy;

  alu_cy_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_code (alu_code),
    .a        (a),
    .r        (r),
    .cy_ce    (cy_ce),
    .out      (out),
    .co       (co),
    .cy       (cy)
`ifdef ALU_ZFLAG_EN
    ,
    .zf       (zf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Integer reference: arithmetic done on plain signed ints, carry/borrow read from range.
  function automatic void ref_alu(input int op, input int av, input int rv, input int ci,
                                  output int o, output int c);
    int t;
    c = 0;
    case (op)
      0: t = av + rv;
      1: t = av + rv + ci;
      2: t = av - rv;
      3: t = av - rv - ci;
      4: t = av & rv;
      5: t = av | rv;
      6: t = av ^ rv;
      default: t = rv;
    endcase
    if (op <= 3) c = (t < 0 || t > 255) ? 1 : 0;
    o = ((t % 256) + 256) % 256;
  endfunction

  task automatic drive(input int op, input int av, input int rv, input int ce);
    int o, c;
    @(negedge clk);
    alu_code = op[2:0];
    a        = av[7:0];
    r        = rv[7:0];
    cy_ce    = ce[0];
    #1;
    ref_alu(op, av, rv, model_cy, o, c);
    check("out_vs_model", out, o);
    check("co_vs_model", co, c);
  endtask

  task automatic clk_edge();
    int o, c;
    ref_alu(int'(alu_code), int'(a), int'(r), model_cy, o, c);
    @(posedge clk);
    if (cy_ce) begin
      model_cy = c;
`ifdef ALU_ZFLAG_EN
      model_zf = (o == 0) ? 1 : 0;
`endif
    end
    #1;
    check("cy_vs_model", cy, model_cy);
`ifdef ALU_ZFLAG_EN
    check("zf_vs_model", zf, model_zf);
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_cy     = 0;
`ifdef ALU_ZFLAG_EN
    model_zf     = 0;
`endif
    rst_n    = 1'b0;
    alu_code = 3'd0;
    a        = 8'd0;
    r        = 8'd0;
    cy_ce    = 1'b0;
    #1;
    check("reset_cy", cy, 0);
`ifdef ALU_ZFLAG_EN
    check("reset_zf", zf, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 8'h08, 8'h04, 0);
    check("add_out", out, 12);
    check("add_co", co, 0);
    clk_edge();

    drive(0, 8'hFF, 8'h01, 1);
    check("add_wrap_out", out, 8'h00);
    check("add_wrap_co", co, 1);
    clk_edge();
    check("add_wrap_cy", cy, 1);

    drive(1, 8'h08, 8'h04, 1);
    check("adc_out", out, 13);
    check("adc_co", co, 0);
    clk_edge();
    check("adc_cy", cy, 0);

    drive(2, 8'h04, 8'h08, 1);
    check("sub_out", out, 8'hFC);
    check("sub_co", co, 1);
    clk_edge();
    check("sub_cy", cy, 1);

    drive(3, 8'h08, 8'h04, 0);
    check("sbb_out", out, 3);
    check("sbb_co", co, 0);
    clk_edge();
    check("sbb_hold_cy", cy, 1);

    drive(4, 8'hF0, 8'h3C, 0);
    check("and_out", out, 8'h30);
    check("and_co", co, 0);
    drive(5, 8'hF0, 8'h3C, 0);
    check("or_out", out, 8'hFC);
    check("or_co", co, 0);
    drive(6, 8'hF0, 8'h3C, 0);
    check("xor_out", out, 8'hCC);
    check("xor_co", co, 0);
    drive(7, 8'hF0, 8'h3C, 0);
    check("pass_out", out, 8'h3C);
    check("pass_co", co, 0);
    clk_edge();
    check("logic_hold_cy", cy, 1);

    drive(2, 8'h00, 8'h01, 0);
    check("sub_wrap_out", out, 8'hFF);
    check("sub_wrap_co", co, 1);
    clk_edge();

    drive(2, 8'h05, 8'h05, 1);
    check("zero_out", out, 0);
    clk_edge();
    check("zero_cy", cy, 0);
`ifdef ALU_ZFLAG_EN
    check("zero_zf", zf, 1);
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(7, 0), $urandom_range(255, 0), $urandom_range(255, 0),
            $urandom_range(1, 0));
      clk_edge();
    end

    // Asynchronous reset must clear cy in the middle of the low clock phase.
    drive(0, 8'hFF, 8'h01, 1);
    clk_edge();
    check("pre_rst_cy", cy, 1);
    @(negedge clk);
    cy_ce = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_cy = 0;
`ifdef ALU_ZFLAG_EN
    model_zf = 0;
`endif
    check("async_rst_cy", cy, 0);
    check("async_rst_clk_low", clk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h08, 8'h04, 1);
    check("post_rst_adc_out", out, 12);
    clk_edge();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
